// File: rtl/svr_feature_loader.sv
// rtl/svr_feature_loader.sv - loads a frame of feature words into the SVR inputs, waits for settle, captures y
// Optional NaN/Inf frame check: define SVR_LOADER_NAN_CHECK_EN
module svr_feature_loader #(
  parameter int NUM_FEATURES  = 9,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] x1,
  output logic [31:0] x2,
  output logic [31:0] x3,
  output logic [31:0] x4,
  output logic [31:0] x5,
  output logic [31:0] x6,
  output logic [31:0] x7,
  output logic [31:0] x8,
  output logic [31:0] x9,
  input  logic [31:0] y_in,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  localparam logic [3:0] LAST_IDX    = 4'(NUM_FEATURES - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  idx;
  logic [3:0]  settle_cnt;
  logic [31:0] x_r [0:8];
  logic        accept;
  logic        out_done;

  assign s_ready  = (state == ST_LOAD) && !rst;
  assign accept   = s_valid && s_ready;
  assign out_done = (state == ST_OUTPUT) && m_ready;
  assign busy     = (state != ST_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_LOAD;
      idx        <= 4'd0;
      settle_cnt <= 4'd0;
      m_data     <= 32'h0;
      m_valid    <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              idx        <= 4'd0;
              settle_cnt <= 4'd0;
              state      <= ST_SETTLE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        ST_SETTLE: begin
          // y_in is sampled only once the datapath has had its full settle window
          if (settle_cnt == SETTLE_LAST) begin
            m_data  <= y_in;
            m_valid <= 1'b1;
            state   <= ST_OUTPUT;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_OUTPUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) x_r[i] <= 32'h0;
    end else if (accept) begin
      for (int i = 0; i < 9; i++) begin
        if (idx == 4'(i)) x_r[i] <= s_data;
      end
    end
  end

  assign x1 = x_r[0];
  assign x2 = x_r[1];
  assign x3 = x_r[2];
  assign x4 = x_r[3];
  assign x5 = x_r[4];
  assign x6 = x_r[5];
  assign x7 = x_r[6];
  assign x8 = x_r[7];
  assign x9 = x_r[8];

`ifdef SVR_LOADER_NAN_CHECK_EN
  logic nan_flag;

  // Sticky across the whole frame; only the result handshake or reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      nan_flag <= 1'b0;
    end else if (out_done) begin
      nan_flag <= 1'b0;
    end else if (accept && (s_data[30:23] == 8'hFF)) begin
      nan_flag <= 1'b1;
    end
  end

  assign err = m_valid && nan_flag;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_svr_feature_loader.sv
// tb/tb_svr_feature_loader.sv - randomized self-checking bench for svr_feature_loader against a frame-level model
module tb_svr_feature_loader;

`ifdef SVR_LOADER_NAN_CHECK_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif
  localparam logic [31:0] BIAS   = 32'hC3C00E4C;
  localparam int          SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = 32'h0;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] y_in;
  logic        s_ready, m_valid, busy, err;
  logic [31:0] m_data;
  logic [31:0] x1, x2, x3, x4, x5, x6, x7, x8, x9;
  logic [31:0] xo [9];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;

  svr_feature_loader dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7), .x8(x8), .x9(x9),
    .y_in(y_in), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign xo[0] = x1; assign xo[1] = x2; assign xo[2] = x3;
  assign xo[3] = x4; assign xo[4] = x5; assign xo[5] = x6;
  assign xo[6] = x7; assign xo[7] = x8; assign xo[8] = x9;

  // Stand-in SVR model: all-zero features give the bias, anything else folds the inputs in
  function automatic logic [31:0] svr_f(input logic [31:0] v [9]);
    logic [31:0] acc;
    acc = BIAS;
    for (int i = 0; i < 9; i++) acc = acc ^ ((v[i] << i) | (v[i] >> (32 - i)));
    return acc;
  endfunction

  always_comb y_in = svr_f(xo);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Frame-level model: words collected so far, a countdown to the result, and a pending result
  logic [31:0] mx [9];
  int          m_n = 0;
  int          m_settle = 0;
  bit          m_out = 0, m_nan = 0, m_oerr = 0;
  logic [31:0] m_odata = 32'h0;
  bit          started = 0;

  initial begin
    for (int i = 0; i < 9; i++) mx[i] = 32'h0;
    forever begin
      @(negedge clk);
      if (started) begin
        check("s_ready", {31'b0, s_ready}, {31'b0, !rst && m_settle == 0 && !m_out});
        check("busy", {31'b0, busy}, {31'b0, m_settle > 0 || m_out});
        check("m_valid", {31'b0, m_valid}, {31'b0, m_out});
        check("m_data", m_data, m_odata);
        check("err", {31'b0, err}, {31'b0, m_out && m_oerr && NAN_EN});
        for (int i = 0; i < 9; i++) check($sformatf("x%0d", i + 1), xo[i], mx[i]);
      end
      if (rst) begin
        for (int i = 0; i < 9; i++) mx[i] = 32'h0;
        m_n = 0; m_settle = 0; m_out = 0; m_nan = 0; m_oerr = 0; m_odata = 32'h0;
      end else if (m_out) begin
        if (m_ready) begin m_out = 0; m_nan = 0; end
      end else if (m_settle > 0) begin
        m_settle--;
        if (m_settle == 0) begin m_out = 1; m_odata = svr_f(mx); m_oerr = m_nan; end
      end else if (s_valid) begin
        mx[m_n] = s_data;
        if (s_data[30:23] == 8'hFF) m_nan = 1;
        m_n++;
        if (m_n == 9) begin m_n = 0; m_settle = SETTLE; end
      end
      started = 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit gap);
    int k;
    k = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && k < 50) begin tick; k++; end
    if (!s_ready) check("send_timeout", 32'd0, 32'd1);
    last_acc = cyc;
    tick;
    s_valid = 1'b0;
    if (gap) tick;
  endtask

  task automatic wait_mv(output int lat);
    int k;
    k = 0;
    while (!m_valid && k < 40) begin tick; k++; end
    if (!m_valid) check("m_valid_timeout", 32'd0, 32'd1);
    lat = cyc - last_acc;
  endtask

  task automatic handshake;
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
  endtask

  initial begin
    int          lat, acc, hs;
    logic [31:0] vals [9];
    logic [31:0] exp_y;

    tick; tick;
    check("s_ready_in_rst", {31'b0, s_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("s_ready_after_rst", {31'b0, s_ready}, 32'd1);
    check("busy_after_rst", {31'b0, busy}, 32'd0);
    check("m_valid_after_rst", {31'b0, m_valid}, 32'd0);
    check("m_data_after_rst", m_data, 32'h0);
    check("err_after_rst", {31'b0, err}, 32'd0);
    for (int i = 0; i < 9; i++) check($sformatf("x%0d_after_rst", i + 1), xo[i], 32'h0);

    // Zero frame, back-to-back words, consumer always ready
    m_ready = 1'b1;
    for (int i = 0; i < 9; i++) send(32'h0, 1'b0);
    wait_mv(lat);
    check("zero_latency", lat, 32'd3);
    check("zero_m_data", m_data, BIAS);
    check("zero_err", {31'b0, err}, 32'd0);
    tick;
    m_ready = 1'b0;

    // 1.0 .. 9.0 with s_valid toggling
    vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
             32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
    for (int i = 0; i < 9; i++) send(vals[i], 1'b1);
    wait_mv(lat);
    check("toggle_latency", lat, 32'd3);
    for (int i = 0; i < 9; i++) check($sformatf("order_x%0d", i + 1), xo[i], vals[i]);

    // Stall the consumer for 5 cycles while offering unwanted input
    exp_y = svr_f(vals);
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      check("stall_m_data", m_data, exp_y);
      check("stall_m_valid", {31'b0, m_valid}, 32'd1);
      check("stall_s_ready", {31'b0, s_ready}, 32'd0);
      check("stall_busy", {31'b0, busy}, 32'd1);
      tick;
    end
    s_valid = 1'b0;
    handshake;
    check("post_hs_s_ready", {31'b0, s_ready}, 32'd1);
    check("post_hs_m_valid", {31'b0, m_valid}, 32'd0);
    check("post_hs_x9", x9, 32'h41100000);

    // Reset mid-frame after 4 words
    for (int i = 0; i < 4; i++) send($urandom | 32'h1, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("rst_x%0d", i + 1), xo[i], 32'h0);
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    for (int i = 0; i < 9; i++) send($urandom & 32'hBFFFFFFF, 1'b0);
    wait_mv(lat);
    check("clean_latency", lat, 32'd3);
    handshake;

    // NaN in the third word, then a clean frame
    for (int i = 0; i < 9; i++) send((i == 2) ? 32'h7FC00000 : ($urandom & 32'hBFFFFFFF), 1'b0);
    wait_mv(lat);
    check("nan_err", {31'b0, err}, {31'b0, NAN_EN});
    handshake;
    check("nan_err_cleared", {31'b0, err}, 32'd0);
    for (int i = 0; i < 9; i++) send($urandom & 32'hBFFFFFFF, 1'b0);
    wait_mv(lat);
    check("clean_err", {31'b0, err}, 32'd0);
    handshake;

    // s_valid held high across two frames
    acc = 0;
    hs  = 0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 100 && hs < 2; k++) begin
      s_data = $urandom;
      if (s_ready) acc++;
      if (m_valid && m_ready) hs++;
      tick;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("stream_handshakes", hs, 32'd2);
    check("stream_accepts", acc, 32'd18);

    // Random traffic, occasional Inf/NaN exponents and resets
    for (int k = 0; k < 1500; k++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = ($urandom_range(0, 2) != 0);
      s_data  = $urandom;
      if ($urandom_range(0, 7) == 0) s_data[30:23] = 8'hFF;
      rst = ($urandom_range(0, 149) == 0);
      tick;
    end
    rst = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    tick; tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/svr_feature_loader.md
SVR_FEATURE_LOADER -- requirements
Module: svr_feature_loader

Interface
REQ-001 The block SHALL have parameter NUM_FEATURES, default 9: feature words per inference frame.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 2, legal range 1-15: cycles allowed for the combinational SVR datapath to settle.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all logic on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port s_data, input, 32 bits: incoming IEEE 754 single-precision feature word.
REQ-006 The block SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-007 The block SHALL have port s_ready, output, 1 bit: the loader accepts s_data.
REQ-008 The block SHALL have ports x1..x9, output, 32 bits each: registered feature words driving the SVR model inputs.
REQ-009 The block SHALL have port y_in, input, 32 bits: the SVR model result y.
REQ-010 The block SHALL have port m_data, output, 32 bits: captured inference result.
REQ-011 The block SHALL have port m_valid, output, 1 bit: m_data is valid.
REQ-012 The block SHALL have port m_ready, input, 1 bit: the downstream consumer accepts m_data.
REQ-013 The block SHALL have port busy, output, 1 bit: high in SETTLE or OUTPUT.
REQ-014 The block SHALL have port err, output, 1 bit: frame error flag (see Configuration).

Function
REQ-015 The block SHALL implement three FSM states, LOAD, SETTLE and OUTPUT, with LOAD as the reset state.
REQ-016 In LOAD, s_ready SHALL be 1; an accept is s_valid&&s_ready in the same cycle; each accept SHALL write s_data to x[idx] and increment the 4-bit index idx.
REQ-017 Words SHALL fill x1 first and x9 last; gaps in s_valid SHALL be allowed, and idx SHALL hold while s_valid=0.
REQ-018 The accept with idx=NUM_FEATURES-1 SHALL move the FSM to SETTLE on the next edge, clear the settle counter and clear idx to 0.
REQ-019 In SETTLE and OUTPUT, s_ready SHALL be 0 and x1..x9 SHALL hold unchanged, keeping the model inputs stable.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles; on its last cycle y_in SHALL be registered into m_data, and m_valid=1 from the next cycle with the FSM in OUTPUT.
REQ-021 Latency: if the last word is accepted in cycle T, m_valid SHALL first be 1 in cycle T+1+SETTLE_CYCLES.
REQ-022 In OUTPUT, m_data and m_valid SHALL hold stable until m_valid&&m_ready; on that edge m_valid SHALL become 0 and the FSM SHALL return to LOAD.
REQ-023 A new frame's first word SHALL be accepted no earlier than the cycle after the output handshake; there is no overlap between frames.
REQ-024 m_ready asserted outside OUTPUT SHALL have no effect, and s_valid outside LOAD SHALL be ignored with no data written.
REQ-025 No arithmetic SHALL be performed on data words; they pass through bit-exact.

Reset
REQ-026 When rst=1 at an edge, the block SHALL set state=LOAD, idx=0, x1..x9=32'h0, m_data=32'h0, m_valid=0, err=0 and the settle counter to 0.
REQ-027 s_ready SHALL be 0 while rst=1, and 1 in the first cycle after rst deasserts.
REQ-028 Reset in any state, mid-frame or mid-handshake, SHALL discard the partial frame and any pending result.

Configuration
REQ-029 With macro SVR_LOADER_NAN_CHECK_EN defined, any accepted word with exponent bits [30:23]=8'hFF (NaN or Inf) SHALL set a sticky per-frame error flag.
REQ-030 With SVR_LOADER_NAN_CHECK_EN defined, err SHALL equal that flag while m_valid=1 and be 0 otherwise; the flag SHALL clear on the output handshake or on reset; the frame SHALL still complete normally.
REQ-031 Without SVR_LOADER_NAN_CHECK_EN, err SHALL be tied to 0 and no checking logic SHALL exist.

Verification
REQ-032 The bench SHALL cover: nine 32'h00000000 words on consecutive cycles, m_ready=1, loader wired to the SVR model -> m_valid in cycle T+3, m_data=32'hC3C00E4C (bias), err=0.
REQ-033 The bench SHALL cover: words 32'h3F800000..(nine distinct values) with s_valid toggling every other cycle -> x1..x9 match send order; m_valid exactly 3 cycles after the 9th accept.
REQ-034 The bench SHALL cover: m_ready held 0 for 5 cycles in OUTPUT -> m_data stable, m_valid=1, s_ready=0, busy=1 throughout; handshake on cycle 6 -> LOAD, s_ready=1 next cycle.
REQ-035 The bench SHALL cover: rst pulsed for 1 cycle after 4 accepted words -> idx=0, x1..x4=0, m_valid=0; the next 9 words form a clean frame.
REQ-036 The bench SHALL cover, with SVR_LOADER_NAN_CHECK_EN: 3rd word=32'h7FC00000 -> err=1 together with m_valid; the next clean frame has err=0. Without the macro, err=0 always.
REQ-037 The bench SHALL cover: s_valid held 1 continuously across two frames -> exactly 9 accepts per frame, none accepted during SETTLE or OUTPUT.
